inst_mem_loader: RTL

Host-side writer for the PE instruction memory. It accepts 32-bit host words over a valid/ready handshake and packs every three words into one INST_DWIDTH-bit instruction. It writes the instructions sequentially into the instruction memory write port. On command it asserts PE_Array_Busy for a programmed number of cycles, which lets the PE instruction sequencer step, then signals completion.

---
 rtl/inst_mem_loader_pkg.sv | 74 +++++++
 rtl/inst_mem_loader_packer.sv | 60 ++++++
 rtl/inst_mem_loader.sv | 205 ++++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_loader_pkg.sv
// inst_mem_loader_pkg
//   Shared definitions for the PE instruction memory loader. It holds the
//   loader FSM encoding, the number of host words per instruction and the
//   field layout of a 72-bit PE instruction. The PE decoder and the test
//   encoder both use the same layout.
//   No ports (package).
package inst_mem_loader_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } loader_state_t;

    localparam int WORDS_PER_INST = 3;

    // Instruction field slices (bit positions within the 72-bit word).
    localparam int INPUT_SEL_HI  = 67;
    localparam int INPUT_SEL_LO  = 66;
    localparam int BYPASS_SEL_HI = 65;
    localparam int BYPASS_SEL_LO = 64;
    localparam int WEB_BIT       = 63;
    localparam int WEA_BIT       = 62;
    localparam int ADDR3_HI      = 61;
    localparam int ADDR3_LO      = 54;
    localparam int ADDR4_HI      = 53;
    localparam int ADDR4_LO      = 46;
    localparam int ADDR5_HI      = 45;
    localparam int ADDR5_LO      = 38;
    localparam int ADDR0_HI      = 37;
    localparam int ADDR0_LO      = 30;
    localparam int ADDR1_HI      = 29;
    localparam int ADDR1_LO      = 22;
    localparam int ADDR2_HI      = 21;
    localparam int ADDR2_LO      = 14;
    localparam int OPCODE_HI     = 13;
    localparam int OPCODE_LO     = 10;
    localparam int OUT3_SEL_HI   = 7;
    localparam int OUT3_SEL_LO   = 6;
    localparam int OUT2_SEL_HI   = 5;
    localparam int OUT2_SEL_LO   = 4;
    localparam int OUT1_SEL_HI   = 3;
    localparam int OUT1_SEL_LO   = 2;
    localparam int OUT0_SEL_HI   = 1;
    localparam int OUT0_SEL_LO   = 0;

    // Same layout as the slices above, as a packed struct (MSB first).
    // rsvd_hi covers [71:68] and rsvd_lo covers [9:8].
    typedef struct packed {
        logic [3:0] rsvd_hi;
        logic [1:0] input_sel;
        logic [1:0] bypass_sel;
        logic       web;
        logic       wea;
        logic [7:0] addr3;
        logic [7:0] addr4;
        logic [7:0] addr5;
        logic [7:0] addr0;
        logic [7:0] addr1;
        logic [7:0] addr2;
        logic [3:0] opcode;
        logic [1:0] rsvd_lo;
        logic [1:0] out3_sel;
        logic [1:0] out2_sel;
        logic [1:0] out1_sel;
        logic [1:0] out0_sel;
    } pe_inst_t;

    // Extracts the opcode field from a raw instruction word.
    function automatic logic [3:0] inst_opcode(input logic [71:0] inst);
        return inst[OPCODE_HI:OPCODE_LO];
    endfunction

endpackage

// File: rtl/inst_mem_loader_packer.sv
// inst_word_packer
//   Collects host words into one instruction. Word 0 fills the low slot and
//   word 1 fills the middle slot. Word 2 is not stored. Its low byte goes
//   straight into the top of pack_data in the same cycle it is accepted, so
//   the parent can register the full instruction on that edge.
//   Ports:
//     Clk, Resetn    clock, async active-low reset
//     clear          restart at word 0 (new load)
//     accept         a host word transfers this cycle
//     word           host word
//     word_complete  third word of an instruction is being accepted
//     pack_data      packed instruction, valid while word_complete is high
module inst_word_packer
    import inst_mem_loader_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int INST_DWIDTH = 72
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   clear,
    input  logic                   accept,
    input  logic [DWIDTH-1:0]      word,
    output logic                   word_complete,
    output logic [INST_DWIDTH-1:0] pack_data
);

    logic [1:0]        word_idx;
    logic [DWIDTH-1:0] slot0;
    logic [DWIDTH-1:0] slot1;

    // Slot capture and word index. The index wraps to 0 on the last word.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            word_idx <= 2'd0;
            slot0    <= '0;
            slot1    <= '0;
        end else if (clear) begin
            word_idx <= 2'd0;
        end else if (accept) begin
            case (word_idx)
                2'd0: begin
                    slot0    <= word;
                    word_idx <= 2'd1;
                end
                2'd1: begin
                    slot1    <= word;
                    word_idx <= 2'd2;
                end
                default: word_idx <= 2'd0;
            endcase
        end
    end

    assign word_complete = accept && (word_idx == 2'(WORDS_PER_INST - 1));

    // Only the low byte of the third word is kept.
    assign pack_data = {word[INST_DWIDTH-2*DWIDTH-1:0], slot1, slot0};

endmodule

// File: rtl/inst_mem_loader.sv
// inst_mem_loader
//   Host-side writer for the PE instruction memory. Host words arrive over
//   Host_Valid/Host_Ready and are packed three at a time into instructions.
//   The instructions are written sequentially from address 0. A run command
//   holds PE_Array_Busy high for Run_Cycles cycles and then pulses Run_Done.
//   Ports:
//     Clk, Resetn        clock, async active-low reset
//     Load_Start/Len     start a load of Len instructions (1..2^INST_AWIDTH)
//     Host_Data/Valid    host word stream; Host_Ready = word accepted
//     Run_Start/Cycles   start a run of Run_Cycles busy cycles
//     Inst_Wr_*          instruction memory write port
//     PE_Array_Busy      run enable to the PE array
//     Run_Done           1-cycle pulse after the last busy cycle
//     Loaded             a complete program is in memory
//     Error              1-cycle pulse on an illegal command
//   All outputs are registered.
module inst_mem_loader
    import inst_mem_loader_pkg::*;
#(
    parameter int DWIDTH      = 32,
    parameter int INST_DWIDTH = 72,
    parameter int INST_AWIDTH = 10,
    parameter int CWIDTH      = 16
) (
    input  logic                   Clk,
    input  logic                   Resetn,
    input  logic                   Load_Start,
    input  logic [INST_AWIDTH:0]   Load_Len,
    input  logic [DWIDTH-1:0]      Host_Data,
    input  logic                   Host_Valid,
    output logic                   Host_Ready,
    input  logic                   Run_Start,
    input  logic [CWIDTH-1:0]      Run_Cycles,
    output logic                   Inst_Wr_En,
    output logic [INST_AWIDTH-1:0] Inst_Wr_Addr,
    output logic [INST_DWIDTH-1:0] Inst_Wr_Data,
    output logic                   PE_Array_Busy,
    output logic                   Run_Done,
    output logic                   Loaded,
    output logic                   Error
);

    localparam logic [INST_AWIDTH:0]   MAX_LEN  = {1'b1, {INST_AWIDTH{1'b0}}};
    localparam logic [INST_AWIDTH:0]   LEN_ONE  = {{INST_AWIDTH{1'b0}}, 1'b1};
    localparam logic [INST_AWIDTH-1:0] ADDR_ONE = {{(INST_AWIDTH-1){1'b0}}, 1'b1};
    localparam logic [CWIDTH-1:0]      CNT_ONE  = {{(CWIDTH-1){1'b0}}, 1'b1};

    loader_state_t          state_q, state_d;
    logic [INST_AWIDTH-1:0] addr_q, addr_d;
    logic [INST_AWIDTH-1:0] last_addr_q, last_addr_d;
    logic [CWIDTH-1:0]      run_cnt_q, run_cnt_d;
    logic                   load_last_q, load_last_d;

    logic                   host_ready_d;
    logic                   wr_en_d;
    logic [INST_AWIDTH-1:0] wr_addr_d;
    logic [INST_DWIDTH-1:0] wr_data_d;
    logic                   busy_d;
    logic                   done_d;
    logic                   loaded_d;
    logic                   error_d;

    logic                   pack_clear;
    logic                   word_complete;
    logic [INST_DWIDTH-1:0] pack_data;
    logic                   len_legal;

    inst_word_packer #(
        .DWIDTH      (DWIDTH),
        .INST_DWIDTH (INST_DWIDTH)
    ) u_packer (
        .Clk           (Clk),
        .Resetn        (Resetn),
        .clear         (pack_clear),
        .accept        (Host_Valid && Host_Ready),
        .word          (Host_Data),
        .word_complete (word_complete),
        .pack_data     (pack_data)
    );

    assign len_legal = (Load_Len != '0) && (Load_Len <= MAX_LEN);

    // Next-state and next-output logic. Every output is computed here as a
    // _d value and registered below. This keeps outputs glitch-free and lets
    // the write strobe appear exactly one cycle after the completing handshake.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        last_addr_d  = last_addr_q;
        run_cnt_d    = run_cnt_q;
        load_last_d  = load_last_q;
        host_ready_d = Host_Ready;
        wr_en_d      = 1'b0;
        wr_addr_d    = Inst_Wr_Addr;
        wr_data_d    = Inst_Wr_Data;
        busy_d       = PE_Array_Busy;
        done_d       = 1'b0;
        loaded_d     = Loaded;
        error_d      = 1'b0;
        pack_clear   = 1'b0;

        case (state_q)
            IDLE: begin
                host_ready_d = 1'b0;
                busy_d       = 1'b0;
                // Load_Start has priority and silently drops a coincident Run_Start.
                if (Load_Start) begin
                    if (len_legal) begin
                        last_addr_d  = INST_AWIDTH'(Load_Len - LEN_ONE);
                        addr_d       = '0;
                        load_last_d  = 1'b0;
                        pack_clear   = 1'b1;
                        loaded_d     = 1'b0;
                        host_ready_d = 1'b1;
                        state_d      = LOAD;
                    end else begin
                        error_d = 1'b1;
                    end
                end else if (Run_Start) begin
                    if (Loaded) begin
                        run_cnt_d = Run_Cycles;
                        busy_d    = (Run_Cycles != '0);
                        // A zero-length run goes straight to its done pulse.
                        done_d    = (Run_Cycles == '0);
                        state_d   = RUN;
                    end else begin
                        error_d = 1'b1;
                    end
                end
            end

            LOAD: begin
                if (load_last_q) begin
                    // This is the final write cycle. Host_Ready is already low.
                    loaded_d     = 1'b1;
                    load_last_d  = 1'b0;
                    host_ready_d = 1'b0;
                    state_d      = IDLE;
                end else if (word_complete) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = addr_q;
                    wr_data_d = pack_data;
                    // At full depth this wraps to 0, but no further write follows.
                    addr_d    = addr_q + ADDR_ONE;
                    if (addr_q == last_addr_q) begin
                        host_ready_d = 1'b0;
                        load_last_d  = 1'b1;
                    end
                end
            end

            RUN: begin
                if (Run_Done) begin
                    state_d = IDLE;
                end else if (run_cnt_q <= CNT_ONE) begin
                    busy_d    = 1'b0;
                    done_d    = 1'b1;
                    run_cnt_d = '0;
                end else begin
                    run_cnt_d = run_cnt_q - CNT_ONE;
                end
            end

            default: begin
                state_d      = IDLE;
                host_ready_d = 1'b0;
                busy_d       = 1'b0;
            end
        endcase
    end

    // State, counters and registered outputs. Reset aborts any load or run.
    always_ff @(posedge Clk or negedge Resetn) begin
        if (!Resetn) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            last_addr_q   <= '0;
            run_cnt_q     <= '0;
            load_last_q   <= 1'b0;
            Host_Ready    <= 1'b0;
            Inst_Wr_En    <= 1'b0;
            Inst_Wr_Addr  <= '0;
            Inst_Wr_Data  <= '0;
            PE_Array_Busy <= 1'b0;
            Run_Done      <= 1'b0;
            Loaded        <= 1'b0;
            Error         <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            last_addr_q   <= last_addr_d;
            run_cnt_q     <= run_cnt_d;
            load_last_q   <= load_last_d;
            Host_Ready    <= host_ready_d;
            Inst_Wr_En    <= wr_en_d;
            Inst_Wr_Addr  <= wr_addr_d;
            Inst_Wr_Data  <= wr_data_d;
            PE_Array_Busy <= busy_d;
            Run_Done      <= done_d;
            Loaded        <= loaded_d;
            Error         <= error_d;
        end
    end

endmodule
